flappy_core_n: RTL and testbench

Parametrised game-state engine for the flappy-bird display path, replacing the fixed three-pipe controller. Runs on the 100 ms game tick and keeps the bird, N pipes, score and game state. Compared with the three-pipe controller it adds:
- a pipe count set by parameter;
- an LFSR pipe generator;
- a pause mode;
- a floor/ceiling kill;
- a speed ramp driven by score.

Outputs are registered and feed the VGA renderer directly.

---
 rtl/flappy_pkg.sv | 41 ++++
 rtl/flappy_core_n_lfsr16.sv | 22 ++
 rtl/flappy_core_n.sv | 211 +++++++++++++++++++++
 tb/tb_flappy_core_n.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game-state engine.
// Holds the FSM encoding, default geometry, rise/fall constants and a rotate helper.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DEAD  = 2'd3
    } state_t;

    localparam int N_PIPES_DEF      = 3;
    localparam int PIPE_SPACING_DEF = 210;
    localparam int SCREEN_W_DEF     = 640;
    localparam int PIPE_W_DEF       = 50;
    localparam int PIPE_HEAD_DEF    = 23;
    localparam int BIRD_X_DEF       = 70;
    localparam int BIRD_W_DEF       = 16;
    localparam int BIRD_H_DEF       = 16;
    localparam int FLOOR_Y_DEF      = 464;
    localparam int GAP_MIN_DEF      = 100;
    localparam int GAP_SPAN_DEF     = 50;
    localparam int SPEED_MAX_DEF    = 4;
    localparam int LEVEL_STEP_DEF   = 8;

    localparam int SCREEN_H_PLAY = 330;

    localparam logic [3:0] RISE_FLAP   = 4'd8;
    localparam logic [3:0] RISE_ADD    = 4'd5;
    localparam logic [3:0] RISE_MAX    = 4'd13;
    localparam logic [9:0] FALL_STEP   = 10'd4;
    localparam logic [9:0] BIRD_Y_INIT = 10'd240;

    // Rotate left by n (mod 16): top half of the doubled word after shifting.
    function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned n);
        logic [31:0] w;
        w = {v, v} << (n % 16);
        return w[31:16];
    endfunction

endpackage

// File: rtl/flappy_core_n_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every tick.
// Synchronous active-low reset loads the seed; never stalls.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_100ms,
    input  logic        rst,
    output logic [15:0] o_q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
    assign o_q  = r_q;

    always_ff @(posedge clk_100ms) begin
        if (!rst) r_q <= SEED;
        else      r_q <= {r_q[14:0], w_fb};
    end

endmodule

// File: rtl/flappy_core_n.sv
// Flappy game-state engine: bird, N pipes, score, speed ramp, pause, one tick per 100 ms.
// All outputs registered; edge-to-effect latency 1 tick; no backpressure (free-running tick).
module flappy_core_n
    import flappy_pkg::*;
#(
    parameter int          N_PIPES      = N_PIPES_DEF,
    parameter int          PIPE_SPACING = PIPE_SPACING_DEF,
    parameter int          SCREEN_W     = SCREEN_W_DEF,
    parameter int          PIPE_W       = PIPE_W_DEF,
    parameter int          PIPE_HEAD    = PIPE_HEAD_DEF,
    parameter int          BIRD_X       = BIRD_X_DEF,
    parameter int          BIRD_W       = BIRD_W_DEF,
    parameter int          BIRD_H       = BIRD_H_DEF,
    parameter int          FLOOR_Y      = FLOOR_Y_DEF,
    parameter int          GAP_MIN      = GAP_MIN_DEF,
    parameter int          GAP_SPAN     = GAP_SPAN_DEF,
    parameter int          SPEED_MAX    = SPEED_MAX_DEF,
    parameter int          LEVEL_STEP   = LEVEL_STEP_DEF,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk_100ms,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flap,
    input  logic                    pause,
    output logic [1:0]              state,
    output logic [9:0]              bird_y,
    output logic                    bird_rising,
    output logic [10*N_PIPES-1:0]   pipe_x,
    output logic [10*N_PIPES-1:0]   pipe_y,
    output logic [8*N_PIPES-1:0]    pipe_gap,
    output logic [15:0]             score,
    output logic [2:0]              speed,
    output logic                    hit
);

    localparam logic [10:0] L_BIRD_X    = 11'(BIRD_X);
    localparam logic [10:0] L_BIRD_XR   = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] L_BIRD_H    = 11'(BIRD_H);
    localparam logic [10:0] L_PIPE_W    = 11'(PIPE_W);
    localparam logic [10:0] L_SCREEN_W  = 11'(SCREEN_W);
    localparam logic [9:0]  L_FLOOR     = 10'(FLOOR_Y);
    localparam logic [2:0]  L_SPEED_MAX = 3'(SPEED_MAX);
    localparam logic [15:0] L_LVL_STEP  = 16'(LEVEL_STEP);
    localparam int          Y_SPAN      = SCREEN_H_PLAY - 2 * PIPE_HEAD;

    state_t        r_state, w_state_nxt;
    logic          r_start_d, r_flap_d, r_pause_d, r_hit;
    logic [9:0]    r_bird_y, w_bird_nxt;
    logic [3:0]    r_rise, w_rise_f, w_rise_nxt;
    logic [15:0]   r_score, w_score_nxt, r_level, w_level_nxt, w_lvl_sum;
    logic [16:0]   w_score_sum;
    logic [2:0]    r_speed, w_speed_nxt;
    logic [3:0]    w_pass_cnt;
    logic [15:0]   w_lfsr, w_rsrc;
    logic [N_PIPES-1:0] w_pass, w_pcoll;
    logic          w_start_e, w_flap_e, w_pause_e;
    logic          w_run, w_coll, w_init, w_move;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk_100ms (clk_100ms),
        .rst       (rst),
        .o_q       (w_lfsr)
    );

    // During reset the pipes load from the seed, matching what the LFSR will hold.
    assign w_rsrc    = rst ? w_lfsr : LFSR_SEED;

    assign w_start_e = start & ~r_start_d;
    assign w_flap_e  = flap  & ~r_flap_d;
    assign w_pause_e = pause & ~r_pause_d;
    assign w_run     = (r_state == ST_RUN);
    assign w_coll    = (r_bird_y == 10'd0) || (r_bird_y >= L_FLOOR) || (|w_pcoll);
    assign w_init    = w_start_e && ((r_state == ST_IDLE) || (r_state == ST_DEAD));
    assign w_move    = w_run && !w_coll && !w_pause_e;

    always_ff @(posedge clk_100ms) begin
        if (!rst) begin
            r_start_d <= 1'b0;
            r_flap_d  <= 1'b0;
            r_pause_d <= 1'b0;
        end else begin
            r_start_d <= start;
            r_flap_d  <= flap;
            r_pause_d <= pause;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_e) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_coll)         w_state_nxt = ST_DEAD;
                else if (w_pause_e) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: if (w_pause_e) w_state_nxt = ST_RUN;
            ST_DEAD:  if (w_start_e) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100ms) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hit   <= w_run && w_coll;
        end
    end

    always_comb begin
        w_rise_f = r_rise;
        if (w_flap_e) begin
            if (r_rise == 4'd0)                  w_rise_f = RISE_FLAP;
            else if (r_rise >= RISE_MAX - RISE_ADD) w_rise_f = RISE_MAX;
            else                                 w_rise_f = r_rise + RISE_ADD;
        end
        w_rise_nxt = 4'd0;
        w_bird_nxt = r_bird_y;
        if (w_rise_f != 4'd0) begin
            w_rise_nxt = w_rise_f - 4'd1;
            w_bird_nxt = (r_bird_y <= {6'd0, w_rise_f}) ? 10'd0 : r_bird_y - {6'd0, w_rise_f};
        end else begin
            w_bird_nxt = (r_bird_y >= L_FLOOR - FALL_STEP) ? L_FLOOR : r_bird_y + FALL_STEP;
        end
    end

    // One speed step per LEVEL_STEP points; the remainder carries into the next level.
    always_comb begin
        w_pass_cnt = 4'd0;
        for (int i = 0; i < N_PIPES; i++) w_pass_cnt = w_pass_cnt + {3'd0, w_pass[i]};
        w_score_sum = {1'b0, r_score} + {13'd0, w_pass_cnt};
        w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        w_lvl_sum   = r_level + {12'd0, w_pass_cnt};
        w_level_nxt = w_lvl_sum;
        w_speed_nxt = r_speed;
        if (w_lvl_sum >= L_LVL_STEP) begin
            w_level_nxt = w_lvl_sum - L_LVL_STEP;
            if (r_speed < L_SPEED_MAX) w_speed_nxt = r_speed + 3'd1;
        end
    end

    always_ff @(posedge clk_100ms) begin
        if (!rst || w_init) begin
            r_bird_y <= BIRD_Y_INIT;
            r_rise   <= 4'd0;
            r_score  <= 16'd0;
            r_speed  <= 3'd1;
            r_level  <= 16'd0;
        end else if (w_move) begin
            r_bird_y <= w_bird_nxt;
            r_rise   <= w_rise_nxt;
            r_score  <= w_score_nxt;
            r_speed  <= w_speed_nxt;
            r_level  <= w_level_nxt;
        end
    end

    for (genvar gi = 0; gi < N_PIPES; gi++) begin : g_pipe
        localparam logic [9:0] INIT_X = 10'(PIPE_SPACING * (gi + 1));

        logic [9:0]  r_px, r_py, w_y_new;
        logic [7:0]  r_pg, w_gap_new;
        logic [15:0] w_rnd;
        logic [10:0] w_px, w_px_new, w_py_bot, w_by;
        logic        w_respawn;

        // Per-pipe rotation keeps simultaneous respawns from drawing the same value.
        assign w_rnd     = rotl16(w_rsrc, 3 * gi);
        assign w_y_new   = 10'(PIPE_HEAD + int'(w_rnd) % Y_SPAN);
        assign w_gap_new = 8'(GAP_MIN + int'(w_rnd) % GAP_SPAN);

        assign w_px      = {1'b0, r_px};
        assign w_respawn = (w_px <= {8'd0, r_speed});
        assign w_px_new  = w_respawn ? L_SCREEN_W : w_px - {8'd0, r_speed};
        assign w_pass[gi] = (w_px + L_PIPE_W > L_BIRD_X) && (w_px_new + L_PIPE_W <= L_BIRD_X);

        assign w_by       = {1'b0, r_bird_y};
        assign w_py_bot   = {1'b0, r_py} + {3'd0, r_pg};
        assign w_pcoll[gi] = (L_BIRD_X <= w_px + L_PIPE_W) && (L_BIRD_XR >= w_px) &&
                             ((w_by <= {1'b0, r_py}) || (w_by + L_BIRD_H >= w_py_bot));

        always_ff @(posedge clk_100ms) begin
            if (!rst || w_init) begin
                r_px <= INIT_X;
                r_py <= w_y_new;
                r_pg <= w_gap_new;
            end else if (w_move) begin
                r_px <= w_px_new[9:0];
                if (w_respawn) begin
                    r_py <= w_y_new;
                    r_pg <= w_gap_new;
                end
            end
        end

        assign pipe_x[10*gi +: 10]  = r_px;
        assign pipe_y[10*gi +: 10]  = r_py;
        assign pipe_gap[8*gi +: 8]  = r_pg;
    end

    assign state       = r_state;
    assign bird_y      = r_bird_y;
    assign bird_rising = |r_rise;
    assign score       = r_score;
    assign speed       = r_speed;
    assign hit         = r_hit;

endmodule

// File: tb/tb_flappy_core_n.sv
// Directed bench for flappy_core_n: default instance for reset/flap/pause/death,
// and a wide-gap instance (LEVEL_STEP=2) for scoring, speed ramp and reset mid-respawn.
module tb_flappy_core_n;

    logic clk_100ms = 1'b0;
    always #5 clk_100ms = ~clk_100ms;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: default parameters
    logic        a_rst, a_start, a_flap, a_pause;
    logic [1:0]  a_state;
    logic [9:0]  a_bird_y;
    logic        a_rising, a_hit;
    logic [29:0] a_pipe_x, a_pipe_y;
    logic [23:0] a_pipe_gap;
    logic [15:0] a_score;
    logic [2:0]  a_speed;

    // Instance B: every gap is at y 164/165, height 250, so a hovering bird survives
    logic        b_rst, b_start, b_flap, b_pause;
    logic [1:0]  b_state;
    logic [9:0]  b_bird_y;
    logic        b_rising, b_hit;
    logic [29:0] b_pipe_x, b_pipe_y;
    logic [23:0] b_pipe_gap;
    logic [15:0] b_score;
    logic [2:0]  b_speed;

    flappy_core_n u_dut_a (
        .clk_100ms (clk_100ms), .rst (a_rst), .start (a_start), .flap (a_flap), .pause (a_pause),
        .state (a_state), .bird_y (a_bird_y), .bird_rising (a_rising),
        .pipe_x (a_pipe_x), .pipe_y (a_pipe_y), .pipe_gap (a_pipe_gap),
        .score (a_score), .speed (a_speed), .hit (a_hit)
    );

    flappy_core_n #(
        .PIPE_HEAD (164), .GAP_MIN (250), .GAP_SPAN (1), .LEVEL_STEP (2)
    ) u_dut_b (
        .clk_100ms (clk_100ms), .rst (b_rst), .start (b_start), .flap (b_flap), .pause (b_pause),
        .state (b_state), .bird_y (b_bird_y), .bird_rising (b_rising),
        .pipe_x (b_pipe_x), .pipe_y (b_pipe_y), .pipe_gap (b_pipe_gap),
        .score (b_score), .speed (b_speed), .hit (b_hit)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100ms);
        #1;
    endtask

    int          k1, k2, k3, k4;
    logic [2:0]  s2, s4;
    logic        found;

    initial begin
        {a_start, a_flap, a_pause, b_start, b_flap, b_pause} = '0;
        a_rst = 1'b0;
        b_rst = 1'b0;
        k1 = 0; k2 = 0; k3 = 0; k4 = 0; s2 = '0; s4 = '0; found = 1'b0;
        tick();
        tick();

        // Reset values; pipe y/gap come from the seed 0xACE1 (and 0x670D rotated)
        check_eq("rst_state", a_state, 0);
        check_eq("rst_bird",  a_bird_y, 240);
        check_eq("rst_px0",   a_pipe_x[9:0], 210);
        check_eq("rst_px1",   a_pipe_x[19:10], 420);
        check_eq("rst_px2",   a_pipe_x[29:20], 630);
        check_eq("rst_score", a_score, 0);
        check_eq("rst_speed", a_speed, 1);
        check_eq("rst_hit",   a_hit, 0);
        check_eq("rst_py0",   a_pipe_y[9:0], 260);
        check_eq("rst_gap0",  a_pipe_gap[7:0], 107);
        check_eq("rst_py1",   a_pipe_y[19:10], 276);
        check_eq("rst_gap1",  a_pipe_gap[15:8], 131);
        check_eq("b_rst_py0", b_pipe_y[9:0], 165);
        check_eq("b_rst_gap0", b_pipe_gap[7:0], 250);

        // Start
        a_rst = 1'b1;
        tick();
        check_eq("idle_hold", a_state, 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check_eq("start_state", a_state, 1);
        check_eq("start_bird",  a_bird_y, 240);
        check_eq("start_px2",   a_pipe_x[29:20], 630);

        // Flap held for three ticks: a single impulse of 8
        a_flap = 1'b1;
        tick();
        check_eq("flap_y1",  a_bird_y, 232);
        check_eq("flap_rising", a_rising, 1);
        tick();
        check_eq("flap_y2",  a_bird_y, 225);
        tick();
        check_eq("flap_y3",  a_bird_y, 219);
        check_eq("flap_px0", a_pipe_x[9:0], 207);

        // Pause freezes everything, resume continues with the held rise
        a_flap  = 1'b0;
        a_pause = 1'b1;
        tick();
        a_pause = 1'b0;
        check_eq("pause_state", a_state, 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("pause_bird", a_bird_y, 219);
            check_eq("pause_px0",  a_pipe_x[9:0], 207);
        end
        a_pause = 1'b1;
        tick();
        a_pause = 1'b0;
        check_eq("resume_state", a_state, 1);
        check_eq("resume_bird",  a_bird_y, 219);
        tick();
        check_eq("resume_step_bird", a_bird_y, 214);
        check_eq("resume_step_px0",  a_pipe_x[9:0], 206);

        // Free fall to the floor and death
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (55) tick();
        check_eq("fall55_bird",  a_bird_y, 460);
        tick();
        check_eq("fall56_bird",  a_bird_y, 464);
        check_eq("fall56_state", a_state, 1);
        tick();
        check_eq("dead_state", a_state, 3);
        check_eq("dead_hit",   a_hit, 1);
        check_eq("dead_px0",   a_pipe_x[9:0], 154);
        tick();
        check_eq("dead_hit_pulse", a_hit, 0);
        check_eq("dead_hold_state", a_state, 3);
        check_eq("dead_hold_bird",  a_bird_y, 464);
        check_eq("dead_hold_px0",   a_pipe_x[9:0], 154);

        // Restart from DEAD
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check_eq("restart_state", a_state, 1);
        check_eq("restart_bird",  a_bird_y, 240);
        check_eq("restart_px0",   a_pipe_x[9:0], 210);

        // Scoring and speed ramp on instance B; bird hovers in 204..240 via a flap every 17 ticks
        b_rst = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check_eq("b_start_state", b_state, 1);
        for (int k = 1; k <= 700 && k4 == 0; k++) begin
            b_flap = (k % 17 == 1);
            tick();
            if (b_score >= 1 && k1 == 0) k1 = k;
            if (b_score >= 2 && k2 == 0) begin k2 = k; s2 = b_speed; end
            if (b_score >= 3 && k3 == 0) k3 = k;
            if (b_score >= 4 && k4 == 0) begin k4 = k; s4 = b_speed; end
        end
        b_flap = 1'b0;
        check_eq("pass1_tick",   k1, 190);
        check_eq("pass2_tick",   k2, 400);
        check_eq("pass2_speed",  s2, 2);
        check_eq("pass3_tick",   k3, 505);
        check_eq("pass4_tick",   k4, 615);
        check_eq("pass4_speed",  s4, 3);
        check_eq("pass4_score",  b_score, 4);
        check_eq("b_alive",      b_state, 1);

        // Reset asserted on a respawn tick
        for (int j = 0; j < 20 && !found; j++) begin
            for (int p = 0; p < 3; p++)
                if ({7'd0, b_pipe_x[10*p +: 10]} <= {14'd0, b_speed}) found = 1'b1;
            if (!found) tick();
        end
        check_eq("rsp_found", found, 1);
        b_rst = 1'b0;
        tick();
        check_eq("rsp_rst_state", b_state, 0);
        check_eq("rsp_rst_px0",   b_pipe_x[9:0], 210);
        check_eq("rsp_rst_px1",   b_pipe_x[19:10], 420);
        check_eq("rsp_rst_px2",   b_pipe_x[29:20], 630);
        check_eq("rsp_rst_score", b_score, 0);
        check_eq("rsp_rst_speed", b_speed, 1);
        check_eq("rsp_rst_bird",  b_bird_y, 240);
        check_eq("rsp_rst_py0",   b_pipe_y[9:0], 165);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
